// File: rtl/pipe_interlock.sv
// ---------------------------------------------------------------------------
// pipe_interlock
//
// Load-use interlock and destination tracker for the 5-stage pipelined CPU.
// Sits beside the ID stage. It keeps a shadow copy of the destination
// information held by EXE, MEM and WB. From that copy it derives the PC/IF-ID
// write enable, the EXE bubble control, and the operand bypass selects for
// both ID read ports.
//
// Configuration macro:
//   PIPE_INTERLOCK_STATS_EN  - when defined, adds the saturating load-use
//                              stall counter and its stall_cnt output port.
//
// Parameters:
//   NREG_W   register-number width
//   CNT_W    stall counter width (only meaningful with the stats macro)
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   d_valid             ID holds a real (non-squashed) instruction
//   d_rs, d_rt          ID source register numbers
//   d_use_rs, d_use_rt  ID instruction actually reads rs / rt
//   d_wreg, d_m2reg     ID instruction writes the register file / is a load
//   d_rn                ID destination register number
//   flush               squash the ID instruction (taken branch/jump)
//   wpcir               PC and IF/ID write enable, 0 = hold
//   e_bubble            EXE receives a NOP this cycle
//   fwda, fwdb          bypass select for rs / rt:
//                       00 regfile, 01 exe_alu, 10 mem_alu, 11 mem_lw
//   ern, mrn, wrn       tracked EXE/MEM/WB destinations, 0 when stage invalid
//   ewreg, mwreg, wwreg tracked write enables gated by stage valid
//   stall_cnt           load-use stall count (stats build only)
// ---------------------------------------------------------------------------
module pipe_interlock #(
  parameter int NREG_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [NREG_W-1:0] d_rs,
  input  logic [NREG_W-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic              d_wreg,
  input  logic              d_m2reg,
  input  logic [NREG_W-1:0] d_rn,
  input  logic              flush,
  output logic              wpcir,
  output logic              e_bubble,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic [NREG_W-1:0] ern,
  output logic [NREG_W-1:0] mrn,
  output logic [NREG_W-1:0] wrn,
  output logic              ewreg,
  output logic              mwreg,
`ifdef PIPE_INTERLOCK_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic              wwreg
);

  // Shadow copy of one pipeline stage's destination information.
  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic [NREG_W-1:0] rn;
  } stage_t;

  // Bypass select encoding shared by both read ports.
  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_EXE_ALU = 2'b01,
    FWD_MEM_ALU = 2'b10,
    FWD_MEM_LW  = 2'b11
  } fwd_t;

  stage_t            e_q;
  stage_t            m_q;
  stage_t            d_stage;

  // WB only needs to report its destination; whether it was a load no
  // longer matters because the register file is write-first.
  logic              w_valid_q;
  logic              w_wreg_q;
  logic [NREG_W-1:0] w_rn_q;

  logic              e_live;
  logic              m_live;
  logic              rs_hit;
  logic              rt_hit;
  logic              lu;
  logic              bubble;
  fwd_t              sel_a;
  fwd_t              sel_b;

  // Picks the bypass source for one read port. A live load in EXE that
  // matches is left at the register file: the load-use stall covers it and
  // the value is picked up from mem_lw one cycle later. Register 0 never
  // matches because a stage writing r0 is never live.
  function automatic fwd_t fwd_sel(
    input logic              use_src,
    input logic [NREG_W-1:0] src,
    input stage_t            e,
    input logic              e_is_live,
    input stage_t            m,
    input logic              m_is_live
  );
    fwd_t sel;
    sel = FWD_RF;
    if (use_src) begin
      if (e_is_live && (e.rn == src)) begin
        sel = e.m2reg ? FWD_RF : FWD_EXE_ALU;
      end else if (m_is_live && (m.rn == src)) begin
        sel = m.m2reg ? FWD_MEM_LW : FWD_MEM_ALU;
      end
    end
    return sel;
  endfunction

  // Bundle the ID fields into the form that will enter EXE.
  always_comb begin
    d_stage       = '0;
    d_stage.valid = 1'b1;
    d_stage.wreg  = d_wreg;
    d_stage.m2reg = d_m2reg;
    d_stage.rn    = d_rn;
  end

  // A stage only matters for hazards and bypassing when it will really
  // write a non-zero register.
  always_comb begin
    e_live = e_q.valid & e_q.wreg & (e_q.rn != '0);
    m_live = m_q.valid & m_q.wreg & (m_q.rn != '0);
  end

  // Load-use detection. A flushed or empty ID slot never stalls, so flush
  // wins over a simultaneous hazard. Reset forces the idle outputs so the
  // control is well defined before the shadow stages have been cleared.
  always_comb begin
    rs_hit = d_use_rs & (e_q.rn == d_rs);
    rt_hit = d_use_rt & (e_q.rn == d_rt);
    lu     = ~reset & d_valid & ~flush & e_live & e_q.m2reg & (rs_hit | rt_hit);
    bubble = lu | flush | ~d_valid;
  end

  // Bypass selects for both ID read ports, forced to the register file in
  // reset.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (!reset) begin
      sel_a = fwd_sel(d_use_rs, d_rs, e_q, e_live, m_q, m_live);
      sel_b = fwd_sel(d_use_rt, d_rt, e_q, e_live, m_q, m_live);
    end
  end

  assign wpcir    = ~lu;
  assign e_bubble = reset | bubble;
  assign fwda     = sel_a;
  assign fwdb     = sel_b;

  // Shadow pipeline. EXE, MEM and WB always advance; a stalled or squashed
  // ID instruction is replaced by an invalid entry in EXE, while the
  // instruction itself stays in IF/ID through wpcir.
  always_ff @(posedge clock) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_valid_q <= 1'b0;
      w_wreg_q  <= 1'b0;
      w_rn_q    <= '0;
    end else begin
      e_q       <= bubble ? '0 : d_stage;
      m_q       <= e_q;
      w_valid_q <= m_q.valid;
      w_wreg_q  <= m_q.wreg;
      w_rn_q    <= m_q.rn;
    end
  end

  // Reported destinations read as 0 and write enables as 0 whenever the
  // stage holds a bubble.
  always_comb begin
    ern   = e_q.valid ? e_q.rn : '0;
    mrn   = m_q.valid ? m_q.rn : '0;
    wrn   = w_valid_q ? w_rn_q : '0;
    ewreg = e_q.valid & e_q.wreg;
    mwreg = m_q.valid & m_q.wreg;
    wwreg = w_valid_q & w_wreg_q;
  end

`ifdef PIPE_INTERLOCK_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;

  // Counts every cycle spent holding IF/ID for a load-use hazard and
  // saturates instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (lu && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_interlock.sv
// ---------------------------------------------------------------------------
// tb_pipe_interlock
//
// Self-checking bench for pipe_interlock. Inputs change on the falling edge
// and outputs are compared 1 ns later. A behavioural model keeps the last
// three instructions that left ID (a list of records, newest first) and
// derives the expected control from the hazard and bypass rules.
// ---------------------------------------------------------------------------
module tb_pipe_interlock;

  logic       clock;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       d_wreg;
  logic       d_m2reg;
  logic [4:0] d_rn;
  logic       flush;
  logic       wpcir;
  logic       e_bubble;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic [4:0] ern;
  logic [4:0] mrn;
  logic [4:0] wrn;
  logic       ewreg;
  logic       mwreg;
  logic       wwreg;
`ifdef PIPE_INTERLOCK_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_interlock #(.NREG_W(5), .CNT_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_rs     (d_rs),
    .d_rt     (d_rt),
    .d_use_rs (d_use_rs),
    .d_use_rt (d_use_rt),
    .d_wreg   (d_wreg),
    .d_m2reg  (d_m2reg),
    .d_rn     (d_rn),
    .flush    (flush),
    .wpcir    (wpcir),
    .e_bubble (e_bubble),
    .fwda     (fwda),
    .fwdb     (fwdb),
    .ern      (ern),
    .mrn      (mrn),
    .wrn      (wrn),
    .ewreg    (ewreg),
    .mwreg    (mwreg),
`ifdef PIPE_INTERLOCK_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .wwreg    (wwreg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: history of the instructions that entered EXE, MEM, WB.
  typedef struct {
    bit       v;
    bit       w;
    bit       l;
    bit [4:0] rn;
  } slot_t;

  slot_t      hist [3];
  int unsigned cnt_m = 0;

  function automatic bit writes(slot_t s);
    return s.v && s.w && (s.rn != 5'd0);
  endfunction

  function automatic bit model_lu();
    if (reset || !d_valid || flush) return 1'b0;
    if (!writes(hist[0]) || !hist[0].l) return 1'b0;
    return (d_use_rs && hist[0].rn == d_rs) || (d_use_rt && hist[0].rn == d_rt);
  endfunction

  function automatic bit [1:0] model_fwd(bit use_src, bit [4:0] src);
    if (reset || !use_src) return 2'd0;
    if (writes(hist[0]) && hist[0].rn == src) return hist[0].l ? 2'd0 : 2'd1;
    if (writes(hist[1]) && hist[1].rn == src) return hist[1].l ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  // Drive one cycle's worth of inputs, away from the rising edge.
  task automatic applyStimulus(input bit rst, input bit v, input bit [4:0] rs,
                               input bit [4:0] rt, input bit urs, input bit urt,
                               input bit w, input bit l, input bit [4:0] rn,
                               input bit fl);
    @(negedge clock);
    reset    = rst;
    d_valid  = v;
    d_rs     = rs;
    d_rt     = rt;
    d_use_rs = urs;
    d_use_rt = urt;
    d_wreg   = w;
    d_m2reg  = l;
    d_rn     = rn;
    flush    = fl;
    #1;
  endtask

  // Clock edge plus the matching model update.
  task automatic advance();
    bit lu_now;
    bit bub;
    lu_now = model_lu();
    bub    = lu_now || flush || !d_valid;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
      cnt_m = 0;
    end else begin
      if (lu_now && cnt_m != 65535) cnt_m++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (bub) hist[0] = '{1'b0, 1'b0, 1'b0, 5'd0};
      else     hist[0] = '{1'b1, d_wreg, d_m2reg, d_rn};
    end
  endtask

  task automatic do_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                    1'($urandom));
      checks++;
      if (wpcir !== 1'b1) begin errors++; $display("[TB] FAIL reset_wpcir: got %b expected 1", wpcir); end
      checks++;
      if (fwda !== 2'b00 || fwdb !== 2'b00) begin
        errors++; $display("[TB] FAIL reset_fwd: got fwda=%b fwdb=%b expected 00/00", fwda, fwdb);
      end
      if (c == 1) begin
        checks++;
        if (ern !== 5'd0 || mrn !== 5'd0 || wrn !== 5'd0) begin
          errors++; $display("[TB] FAIL reset_rn: got ern=%0d mrn=%0d wrn=%0d expected 0/0/0", ern, mrn, wrn);
        end
      end
      advance();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (e_bubble !== 1'b1) begin errors++; $display("[TB] FAIL reset_bubble: got %b expected 1", e_bubble); end
`ifdef PIPE_INTERLOCK_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cnt); end
`endif
    advance();
  endtask

  task automatic test_alu_chain();
    do_reset();
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 5'd3, 0);   // add r3
    advance();
    applyStimulus(0, 1, 5'd3, 5'd1, 1, 1, 1, 0, 5'd4, 0);   // sub r4, r3, r1
    checks++;
    if (fwda !== 2'b01) begin errors++; $display("[TB] FAIL alu_fwda: got %b expected 01", fwda); end
    checks++;
    if (wpcir !== 1'b1) begin errors++; $display("[TB] FAIL alu_wpcir: got %b expected 1", wpcir); end
    advance();
    applyStimulus(0, 1, 5'd2, 5'd3, 1, 1, 1, 0, 5'd6, 0);   // or r6, r2, r3
    checks++;
    if (fwdb !== 2'b10) begin errors++; $display("[TB] FAIL alu_fwdb: got %b expected 10", fwdb); end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd5, 0);   // lw r5
    advance();
    applyStimulus(0, 1, 5'd5, 5'd0, 1, 0, 1, 0, 5'd6, 0);
    checks++;
    if (wpcir !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_wpcir: got %b expected 0", wpcir); end
    checks++;
    if (e_bubble !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall_bubble: got %b expected 1", e_bubble); end
    advance();
    applyStimulus(0, 1, 5'd5, 5'd0, 1, 0, 1, 0, 5'd6, 0);   // held instruction
    checks++;
    if (fwda !== 2'b11) begin errors++; $display("[TB] FAIL lu_fwda: got %b expected 11", fwda); end
    checks++;
    if (wpcir !== 1'b1) begin errors++; $display("[TB] FAIL lu_release_wpcir: got %b expected 1", wpcir); end
    checks++;
    if (ern !== 5'd0 || mrn !== 5'd5) begin
      errors++; $display("[TB] FAIL lu_rn: got ern=%0d mrn=%0d expected 0/5", ern, mrn);
    end
    advance();
  endtask

  task automatic test_reg0_and_wb();
    do_reset();
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd0, 0);   // lw r0
    advance();
    applyStimulus(0, 1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd2, 0);
    checks++;
    if (wpcir !== 1'b1 || fwda !== 2'b00 || fwdb !== 2'b00) begin
      errors++; $display("[TB] FAIL reg0: got wpcir=%b fwda=%b fwdb=%b expected 1/00/00", wpcir, fwda, fwdb);
    end
    do_reset();
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 5'd9, 0);   // add r9
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 1, 5'd9, 5'd9, 1, 1, 0, 0, 5'd0, 0);
    checks++;
    if (fwda !== 2'b00 || fwdb !== 2'b00) begin
      errors++; $display("[TB] FAIL wb_only: got fwda=%b fwdb=%b expected 00/00", fwda, fwdb);
    end
    checks++;
    if (wrn !== 5'd9 || wwreg !== 1'b1) begin
      errors++; $display("[TB] FAIL wb_track: got wrn=%0d wwreg=%b expected 9/1", wrn, wwreg);
    end
    advance();
  endtask

  task automatic test_flush_hazard();
    do_reset();
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd7, 0);   // lw r7
    advance();
    applyStimulus(0, 1, 5'd7, 5'd7, 1, 1, 1, 0, 5'd8, 1);
    checks++;
    if (wpcir !== 1'b1 || e_bubble !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_ctrl: got wpcir=%b e_bubble=%b expected 1/1", wpcir, e_bubble);
    end
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ern !== 5'd0 || ewreg !== 1'b0 || mrn !== 5'd7) begin
      errors++; $display("[TB] FAIL flush_next: got ern=%0d ewreg=%b mrn=%0d expected 0/0/7", ern, ewreg, mrn);
    end
    advance();
  endtask

`ifdef PIPE_INTERLOCK_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 5'd5, 0);
      advance();
      applyStimulus(0, 1, 5'd1, 5'd5, 0, 1, 1, 0, 5'd6, 0);
      advance();
      applyStimulus(0, 1, 5'd1, 5'd5, 0, 1, 1, 0, 5'd6, 0);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL stats_count: got %0d expected 3", stall_cnt); end
    advance();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stats_clear: got %0d expected 0", stall_cnt); end
    advance();
  endtask
`endif

  // Random instruction stream over a small register set so hazards are
  // frequent. A stalled instruction is re-presented, as IF/ID would hold it.
  task automatic test_random();
    bit       held;
    bit       rst, v, urs, urt, w, l, fl;
    bit [4:0] rs, rt, rn;
    bit       exp_lu;
    held = 1'b0;
    {rst, v, urs, urt, w, l, fl} = '0;
    {rs, rt, rn} = '0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        v   = ($urandom_range(0, 7) != 0);
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        urs = 1'($urandom);
        urt = 1'($urandom);
        w   = ($urandom_range(0, 3) != 0);
        l   = 1'($urandom);
        rn  = 5'($urandom_range(0, 3));
      end
      fl  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      applyStimulus(rst, v, rs, rt, urs, urt, w, l, rn, fl);
      exp_lu = model_lu();
      checks++;
      if (wpcir !== !exp_lu) begin
        errors++; $display("[TB] FAIL rnd_wpcir c=%0d: got %b expected %b", c, wpcir, !exp_lu);
      end
      checks++;
      if (e_bubble !== (reset || exp_lu || flush || !d_valid)) begin
        errors++; $display("[TB] FAIL rnd_bubble c=%0d: got %b expected %b", c, e_bubble,
                           reset || exp_lu || flush || !d_valid);
      end
      checks++;
      if (fwda !== model_fwd(d_use_rs, d_rs) || fwdb !== model_fwd(d_use_rt, d_rt)) begin
        errors++; $display("[TB] FAIL rnd_fwd c=%0d: got %b/%b expected %b/%b", c, fwda, fwdb,
                           model_fwd(d_use_rs, d_rs), model_fwd(d_use_rt, d_rt));
      end
      checks++;
      if (ern !== (hist[0].v ? hist[0].rn : 5'd0) || mrn !== (hist[1].v ? hist[1].rn : 5'd0) ||
          wrn !== (hist[2].v ? hist[2].rn : 5'd0)) begin
        errors++; $display("[TB] FAIL rnd_rn c=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c, ern, mrn, wrn,
                           hist[0].v ? hist[0].rn : 5'd0, hist[1].v ? hist[1].rn : 5'd0,
                           hist[2].v ? hist[2].rn : 5'd0);
      end
      checks++;
      if ({ewreg, mwreg, wwreg} !== {hist[0].v && hist[0].w, hist[1].v && hist[1].w, hist[2].v && hist[2].w}) begin
        errors++; $display("[TB] FAIL rnd_wreg c=%0d: got %b%b%b expected %b%b%b", c, ewreg, mwreg, wwreg,
                           hist[0].v && hist[0].w, hist[1].v && hist[1].w, hist[2].v && hist[2].w);
      end
`ifdef PIPE_INTERLOCK_STATS_EN
      checks++;
      if (stall_cnt !== 16'(cnt_m)) begin
        errors++; $display("[TB] FAIL rnd_cnt c=%0d: got %0d expected %0d", c, stall_cnt, cnt_m);
      end
`endif
      held = exp_lu;
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    {d_valid, d_use_rs, d_use_rt, d_wreg, d_m2reg, flush} = '0;
    {d_rs, d_rt, d_rn} = '0;
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 1'b0, 1'b0, 5'd0};
    test_reset();
    test_alu_chain();
    test_load_use();
    test_reg0_and_wb();
    test_flush_hazard();
`ifdef PIPE_INTERLOCK_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
